// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : led_seq_pkg
// Description : Shared constants for the LED blink sequencer: FSM state
//               encodings, host register map and CTRL bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package led_seq_pkg;

    // FSM state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_DWELL = 2'd2;
    localparam logic [1:0] c_ST_ADV   = 2'd3;

    // Host word-address map (table lives at 0x20-0x3F, selected by addr[5])
    localparam logic [5:0] c_ADDR_CTRL     = 6'h00;
    localparam logic [5:0] c_ADDR_NSTEPS   = 6'h01;
    localparam logic [5:0] c_ADDR_DWELL_LO = 6'h02;
    localparam logic [5:0] c_ADDR_DWELL_HI = 6'h03;

    // CTRL register bit positions
    localparam int c_CTRL_START = 0;
    localparam int c_CTRL_STOP  = 1;
    localparam int c_CTRL_LOOP  = 2;

endpackage : led_seq_pkg
`default_nettype wire

// File: rtl/led_blink_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : led_blink_sequencer_if
// Description : Host MMIO write bus into the sequencer and the blinker MMIO
//               write bus driven by the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_blink_sequencer_if;

    logic        host_cs;
    logic        host_wr;
    logic [5:0]  host_addr;
    logic [15:0] host_wr_data;

    logic        blk_cs;
    logic        blk_wr_en;
    logic [3:0]  blk_address;
    logic [15:0] blk_wr_data;

    // Host side: issues host writes, observes the blinker bus
    modport master (
        output host_cs, host_wr, host_addr, host_wr_data,
        input  blk_cs, blk_wr_en, blk_address, blk_wr_data
    );

    // Sequencer side: accepts host writes, drives the blinker bus
    modport slave (
        input  host_cs, host_wr, host_addr, host_wr_data,
        output blk_cs, blk_wr_en, blk_address, blk_wr_data
    );

endinterface : led_blink_sequencer_if
`default_nettype wire

// File: rtl/led_seq_table.sv
`default_nettype none
// ============================================================================
// Module      : led_seq_table
// Description : DEPTH x 4 x 16-bit pattern table. One synchronous host write
//               port, one combinational read port indexed by {step, led}.
// Revision    : 1.0 - initial release
// ============================================================================
module led_seq_table #(
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     wr_en,
    input  wire logic [$clog2(DEPTH)-1:0] wr_step,
    input  wire logic [1:0]               wr_led,
    input  wire logic [15:0]              wr_data,
    input  wire logic [$clog2(DEPTH)-1:0] rd_step,
    input  wire logic [1:0]               rd_led,
    output logic      [15:0]              rd_data
);

    logic [15:0] r_mem [DEPTH*4];

    // Table storage: cleared on reset, single-entry host write otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH * 4; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[{wr_step, wr_led}] <= wr_data;
        end
    end

    assign rd_data = r_mem[{rd_step, rd_led}];

endmodule : led_seq_table
`default_nettype wire

// File: rtl/led_blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_blink_sequencer
// Description : Plays a host-programmed table of per-LED blink periods into
//               the four-channel blinker, one step at a time, with a dwell
//               between steps and optional looping.
// Revision    : 1.0 - initial release
// ============================================================================
module led_blink_sequencer
    import led_seq_pkg::*;
#(
    parameter int         DEPTH      = 8,
    parameter logic [1:0] PERIOD_OFS = 2'd0,
    parameter int         DWELL_W    = 32      // supported range 17..32
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    led_blink_sequencer_if.slave          bus,
    output logic                          busy,
    output logic      [$clog2(DEPTH)-1:0] step_idx,
    output logic                          done
);

    localparam int               SW          = $clog2(DEPTH);
    localparam logic [15:0]      c_DEPTH_16  = 16'(DEPTH);
    localparam logic [SW:0]      c_DEPTH_N   = (SW+1)'(DEPTH);
    localparam logic [SW:0]      c_ONE_N     = (SW+1)'(1);
    localparam logic [SW-1:0]    c_ONE_STEP  = SW'(1);
    localparam logic [DWELL_W-1:0] c_ONE_CNT = DWELL_W'(1);

    // Host decode
    logic w_host_we, w_ctrl_we, w_start, w_stop, w_tbl_we;
    logic [SW:0] w_nsteps_wr;

    // Configuration
    logic               r_loop;
    logic [SW:0]        r_nsteps;
    logic [DWELL_W-1:0] r_dwell;

    // Sequencing state
    logic [1:0]         r_state, w_state_nxt;
    logic [1:0]         r_led, w_led_nxt;
    logic [SW-1:0]      r_step, w_step_nxt;
    logic [DWELL_W-1:0] r_cnt, w_cnt_nxt;
    logic               w_done_nxt, w_last;
    logic [15:0]        w_tbl_rd;

    // Registered blinker bus
    logic        r_blk_cs;
    logic [3:0]  r_blk_address;
    logic [15:0] r_blk_wr_data;

    assign w_host_we = bus.host_cs & bus.host_wr;
    assign w_ctrl_we = w_host_we && (bus.host_addr == c_ADDR_CTRL);
    assign w_start   = w_ctrl_we & bus.host_wr_data[c_CTRL_START];
    assign w_stop    = w_ctrl_we & bus.host_wr_data[c_CTRL_STOP];
    assign w_tbl_we  = w_host_we && bus.host_addr[5] && (int'(bus.host_addr[4:2]) < DEPTH);
    assign w_last    = ({1'b0, r_step} == (r_nsteps - c_ONE_N));

    // NSTEPS write value: 0 reads as 1, anything above DEPTH saturates
    always_comb begin
        w_nsteps_wr = bus.host_wr_data[SW:0];
        if (bus.host_wr_data == 16'd0) begin
            w_nsteps_wr = c_ONE_N;
        end else if (bus.host_wr_data > c_DEPTH_16) begin
            w_nsteps_wr = c_DEPTH_N;
        end
    end

    // Host-programmed configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loop   <= 1'b0;
            r_nsteps <= c_ONE_N;
            r_dwell  <= c_ONE_CNT;
        end else if (w_host_we) begin
            case (bus.host_addr)
                c_ADDR_CTRL:     r_loop   <= bus.host_wr_data[c_CTRL_LOOP];
                c_ADDR_NSTEPS:   r_nsteps <= w_nsteps_wr;
                c_ADDR_DWELL_LO: r_dwell[15:0] <= bus.host_wr_data;
                c_ADDR_DWELL_HI: r_dwell[DWELL_W-1:16] <= bus.host_wr_data[DWELL_W-17:0];
                default: ;
            endcase
        end
    end

    // Next-state logic; stop overrides everything, including a same-write start
    always_comb begin
        w_state_nxt = r_state;
        w_led_nxt   = r_led;
        w_step_nxt  = r_step;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        if (w_stop) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_start) begin
                        w_state_nxt = c_ST_LOAD;
                        w_led_nxt   = 2'd0;
                        w_step_nxt  = '0;
                    end
                end
                c_ST_LOAD: begin
                    if (r_led == 2'd3) begin
                        w_state_nxt = c_ST_DWELL;
                        w_led_nxt   = 2'd0;
                        w_cnt_nxt   = (r_dwell == '0) ? c_ONE_CNT : r_dwell;
                    end else begin
                        w_led_nxt = r_led + 2'd1;
                    end
                end
                c_ST_DWELL: begin
                    if (r_cnt <= c_ONE_CNT) begin
                        w_state_nxt = c_ST_ADV;
                    end else begin
                        w_cnt_nxt = r_cnt - c_ONE_CNT;
                    end
                end
                c_ST_ADV: begin
                    w_led_nxt = 2'd0;
                    if (!w_last) begin
                        w_state_nxt = c_ST_LOAD;
                        w_step_nxt  = r_step + c_ONE_STEP;
                    end else if (r_loop) begin
                        w_state_nxt = c_ST_LOAD;
                        w_step_nxt  = '0;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // The table is read with the next step/led so the blinker write is
    // registered into the same cycle the FSM sits in LOAD for that LED.
    led_seq_table #(
        .DEPTH (DEPTH)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_tbl_we),
        .wr_step (SW'(bus.host_addr[4:2])),
        .wr_led  (bus.host_addr[1:0]),
        .wr_data (bus.host_wr_data),
        .rd_step (w_step_nxt),
        .rd_led  (w_led_nxt),
        .rd_data (w_tbl_rd)
    );

    // FSM registers, done pulse and registered blinker bus
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_led         <= 2'd0;
            r_step        <= '0;
            r_cnt         <= '0;
            done          <= 1'b0;
            r_blk_cs      <= 1'b0;
            r_blk_address <= 4'd0;
            r_blk_wr_data <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_led         <= w_led_nxt;
            r_step        <= w_step_nxt;
            r_cnt         <= w_cnt_nxt;
            done          <= w_done_nxt;
            r_blk_cs      <= (w_state_nxt == c_ST_LOAD);
            r_blk_address <= (w_state_nxt == c_ST_LOAD) ? {w_led_nxt, PERIOD_OFS} : 4'd0;
            r_blk_wr_data <= (w_state_nxt == c_ST_LOAD) ? w_tbl_rd : 16'd0;
        end
    end

    assign bus.blk_cs      = r_blk_cs;
    assign bus.blk_wr_en   = r_blk_cs;
    assign bus.blk_address = r_blk_address;
    assign bus.blk_wr_data = r_blk_wr_data;
    assign busy            = (r_state != c_ST_IDLE);
    assign step_idx        = r_step;

endmodule : led_blink_sequencer
`default_nettype wire

// File: tb/tb_led_blink_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_blink_sequencer
// Description : Directed self-checking bench for led_blink_sequencer with a
//               timestamped scoreboard of expected blinker writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_blink_sequencer;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
        int          rel;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic [2:0] step_idx;
    logic       done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    int busy_cycles = 0;
    int done_cnt = 0;
    exp_t q[$];

    led_blink_sequencer_if bus ();

    led_blink_sequencer #(
        .DEPTH      (8),
        .PERIOD_OFS (2'd0),
        .DWELL_W    (32)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .busy     (busy),
        .step_idx (step_idx),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every blinker write is popped and compared with
    // address, data and cycle offset relative to the accepted start write.
    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cycles++;
        if (done) done_cnt++;
        if (!rst && (bus.blk_cs || bus.blk_wr_en)) begin
            checks++;
            assert (q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write observed=%0h:%0h expected=none",
                       bus.blk_address, bus.blk_wr_data);
            end
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("blk_wr_en", {31'd0, bus.blk_wr_en}, 32'd1);
                check("blk_address", {28'd0, bus.blk_address}, {28'd0, e.addr});
                check("blk_wr_data", {16'd0, bus.blk_wr_data}, {16'd0, e.data});
                check("write_cycle", cyc - base, e.rel);
            end
        end
    end

    task automatic host_write(input logic [5:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        bus.host_cs      = 1'b1;
        bus.host_wr      = 1'b1;
        bus.host_addr    = a;
        bus.host_wr_data = d;
        @(posedge clk);
        #1;
        bus.host_cs      = 1'b0;
        bus.host_wr      = 1'b0;
    endtask

    // Start write; base is taken so the first LOAD cycle is relative cycle 1
    task automatic start_run(input logic [15:0] ctrl);
        busy_cycles = 0;
        done_cnt    = 0;
        host_write(6'h00, ctrl);
        base = cyc;
    endtask

    task automatic push_step(input int t0, input logic [15:0] d0, input logic [15:0] d1,
                             input logic [15:0] d2, input logic [15:0] d3);
        q.push_back('{4'h0, d0, t0});
        q.push_back('{4'h4, d1, t0 + 1});
        q.push_back('{4'h8, d2, t0 + 2});
        q.push_back('{4'hC, d3, t0 + 3});
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        int n;
        bus.host_cs      = 1'b0;
        bus.host_wr      = 1'b0;
        bus.host_addr    = 6'd0;
        bus.host_wr_data = 16'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_step_idx", {29'd0, step_idx}, 0);
        check("reset_blk_cs", {31'd0, bus.blk_cs}, 0);
        check("reset_blk_addr", {28'd0, bus.blk_address}, 0);
        check("reset_blk_data", {16'd0, bus.blk_wr_data}, 0);

        // Two steps, dwell 3, single shot
        host_write(6'h01, 16'd2);
        host_write(6'h02, 16'd3);
        host_write(6'h03, 16'd0);
        for (int i = 0; i < 8; i++) host_write(6'h20 + 6'(i), 16'(i + 1));
        push_step(1, 16'd1, 16'd2, 16'd3, 16'd4);
        push_step(9, 16'd5, 16'd6, 16'd7, 16'd8);
        start_run(16'h0001);
        wait_done(40, n);
        check("t1_done_cycle", n, 17);
        check("t1_busy_cycles", busy_cycles, 16);
        check("t1_step_idx", {29'd0, step_idx}, 1);
        @(negedge clk);
        check("t1_done_count", done_cnt, 1);
        check("t1_busy_after", {31'd0, busy}, 0);
        check("t1_queue", q.size(), 0);

        // Looping: wraps back to step 0, then stopped during dwell
        push_step(1, 16'd1, 16'd2, 16'd3, 16'd4);
        push_step(9, 16'd5, 16'd6, 16'd7, 16'd8);
        push_step(17, 16'd1, 16'd2, 16'd3, 16'd4);
        push_step(25, 16'd5, 16'd6, 16'd7, 16'd8);
        start_run(16'h0005);
        wait_drain(60);
        host_write(6'h00, 16'h0002);
        @(negedge clk);
        check("t2_busy_after_stop", {31'd0, busy}, 0);
        repeat (10) @(negedge clk);
        check("t2_done_count", done_cnt, 0);

        // Stop while LOAD drives led 1
        push_step(1, 16'd1, 16'd2, 16'd3, 16'd4);
        void'(q.pop_back());
        void'(q.pop_back());
        start_run(16'h0001);
        host_write(6'h00, 16'h0002);
        @(negedge clk);
        check("t3_busy", {31'd0, busy}, 0);
        check("t3_step_idx", {29'd0, step_idx}, 0);
        repeat (10) @(negedge clk);
        check("t3_done_count", done_cnt, 0);
        check("t3_queue", q.size(), 0);

        // NSTEPS=0 and DWELL=0 both read as 1
        host_write(6'h01, 16'd0);
        host_write(6'h02, 16'd0);
        push_step(1, 16'd1, 16'd2, 16'd3, 16'd4);
        start_run(16'h0001);
        wait_done(30, n);
        check("t4_done_cycle", n, 7);
        check("t4_busy_cycles", busy_cycles, 6);
        wait_drain(2);

        // NSTEPS above DEPTH saturates to DEPTH (steps 2..7 hold zeros)
        host_write(6'h01, 16'd100);
        push_step(1, 16'd1, 16'd2, 16'd3, 16'd4);
        push_step(7, 16'd5, 16'd6, 16'd7, 16'd8);
        for (int s = 2; s < 8; s++) push_step(6 * s + 1, 16'd0, 16'd0, 16'd0, 16'd0);
        start_run(16'h0001);
        wait_done(80, n);
        check("t4b_done_cycle", n, 49);
        check("t4b_step_idx", {29'd0, step_idx}, 7);
        wait_drain(2);

        // Start plus stop in one write while idle: nothing happens
        start_run(16'h0003);
        repeat (6) @(negedge clk);
        check("t6_busy_cycles", busy_cycles, 0);
        check("t6_busy", {31'd0, busy}, 0);

        // Reset during dwell: immediate abort, defaults and cleared table
        host_write(6'h01, 16'd1);
        host_write(6'h02, 16'd10);
        push_step(1, 16'd1, 16'd2, 16'd3, 16'd4);
        start_run(16'h0001);
        wait_drain(10);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_busy", {31'd0, busy}, 0);
        check("t5_blk_wr_en", {31'd0, bus.blk_wr_en}, 0);
        check("t5_step_idx", {29'd0, step_idx}, 0);
        push_step(1, 16'd0, 16'd0, 16'd0, 16'd0);
        start_run(16'h0001);
        wait_done(30, n);
        check("t5_default_done_cycle", n, 7);
        wait_drain(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_led_blink_sequencer
`default_nettype wire
